// File: rtl/dps_pkg.sv
// Shared definitions for the HPS/FPGA SRAM mailbox (write and read paths).
package dps_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 10;
    localparam int unsigned VAL_W   = 8;
    localparam int unsigned SEQ_W   = 2;
    localparam int unsigned CNT_W   = 9;
    localparam int unsigned DROP_W  = 16;

    localparam logic [ADDR_W-1:0] ADDR_FLAG      = 8'd0;
    localparam logic [ADDR_W-1:0] ADDR_COUNT     = 8'd1;
    localparam logic [ADDR_W-1:0] ADDR_DATA_BASE = 8'd2;

    localparam int unsigned X_LSB   = 20;
    localparam int unsigned X_MSB   = 29;
    localparam int unsigned Y_LSB   = 8;
    localparam int unsigned Y_MSB   = 17;
    localparam int unsigned VAL_LSB = 0;
    localparam int unsigned VAL_MSB = 7;
    localparam int unsigned SEQ_LSB = 30;
    localparam int unsigned SEQ_MSB = 31;

    typedef enum logic [2:0] {
        POLL_ADDR,
        POLL_WAIT,
        POLL_READ,
        ACCEPT,
        COMMIT_CNT,
        COMMIT_FLAG
    } dps_state_e;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [VAL_W-1:0] val;
    } dps_sample_t;

endpackage

// File: rtl/dps_word_pack.sv
// Packs one heat-map sample (plus batch tag) into a mailbox word and flags out-of-range samples.
module dps_word_pack
    import dps_pkg::*;
#(
    parameter int unsigned X_LIMIT = 640,
    parameter int unsigned Y_LIMIT = 480
) (
    input  dps_sample_t       sample,
    input  logic [SEQ_W-1:0]  seq,
    output logic [DATA_W-1:0] word_c,
    output logic              in_range_c
);

    always_comb begin
        word_c                  = '0;
        word_c[X_MSB:X_LSB]     = sample.x;
        word_c[Y_MSB:Y_LSB]     = sample.y;
        word_c[VAL_MSB:VAL_LSB] = sample.val;
        word_c[SEQ_MSB:SEQ_LSB] = seq;
        in_range_c = (32'(sample.x) < X_LIMIT) && (32'(sample.y) < Y_LIMIT);
    end

endmodule

// File: rtl/write_dps_module.sv
// FPGA-to-HPS mailbox transmitter: streams samples into addresses 2.., then commits count and flag.
// Optional batch sequence tag in word bits [31:30] enabled by WRITE_DPS_SEQ_TAG_EN.
module write_dps_module
    import dps_pkg::*;
#(
    parameter int unsigned       MAX_ENTRIES = 254,
    parameter logic [DATA_W-1:0] FLAG_VALUE  = 32'd1,
    parameter int unsigned       X_LIMIT     = 640,
    parameter int unsigned       Y_LIMIT     = 480
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] sram_readdata,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_writedata,
    output logic              sram_write,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [X_W-1:0]    in_x,
    input  logic [Y_W-1:0]    in_y,
    input  logic [VAL_W-1:0]  in_val,
    input  logic              flush,
    output logic              busy,
    output logic [DROP_W-1:0] drop_count
);

    dps_state_e        state_q, state_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              write_n, ready_n, busy_n;
    logic [DROP_W-1:0] drop_n;
    logic [SEQ_W-1:0]  seq_w;
    logic [DATA_W-1:0] word_c, flag_word_c;
    logic              in_range_c, hs_c;
    dps_sample_t       sample_c;

`ifdef WRITE_DPS_SEQ_TAG_EN
    logic [SEQ_W-1:0] seq_q, seq_n;
    assign seq_w       = seq_q;
    assign flag_word_c = {seq_q, 30'd0} | FLAG_VALUE;
`else
    assign seq_w       = '0;
    assign flag_word_c = FLAG_VALUE;
`endif

    assign sample_c = '{x: in_x, y: in_y, val: in_val};
    assign hs_c     = in_valid && in_ready;

    dps_word_pack #(
        .X_LIMIT (X_LIMIT),
        .Y_LIMIT (Y_LIMIT)
    ) u_pack (
        .sample     (sample_c),
        .seq        (seq_w),
        .word_c     (word_c),
        .in_range_c (in_range_c)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n = state_q;
        count_n = count_q;
        addr_n  = sram_address;
        wdata_n = sram_writedata;
        write_n = 1'b0;
        drop_n  = drop_count;
`ifdef WRITE_DPS_SEQ_TAG_EN
        seq_n   = seq_q;
`endif
        case (state_q)
            POLL_ADDR: begin
                addr_n  = ADDR_FLAG;
                state_n = POLL_WAIT;
            end
            POLL_WAIT: state_n = POLL_READ;
            POLL_READ: begin
                if (sram_readdata == '0) begin
                    count_n = '0;
                    state_n = ACCEPT;
                end else begin
                    state_n = POLL_ADDR;
                end
            end
            ACCEPT: begin
                if (hs_c) begin
                    if (in_range_c) begin
                        addr_n  = ADDR_DATA_BASE + count_q[ADDR_W-1:0];
                        wdata_n = word_c;
                        write_n = 1'b1;
                        count_n = count_q + CNT_W'(1);
                    end else if (drop_count != '1) begin
                        drop_n = drop_count + DROP_W'(1);
                    end
                end
                // A sample arriving with flush is written first, then the batch commits.
                if ((hs_c && in_range_c && count_n == CNT_W'(MAX_ENTRIES)) ||
                    (flush && count_n != '0)) begin
                    state_n = COMMIT_CNT;
                end
            end
            COMMIT_CNT: begin
                addr_n  = ADDR_COUNT;
                wdata_n = DATA_W'(count_q);
                write_n = 1'b1;
                state_n = COMMIT_FLAG;
            end
            COMMIT_FLAG: begin
                addr_n  = ADDR_FLAG;
                wdata_n = flag_word_c;
                write_n = 1'b1;
                state_n = POLL_ADDR;
`ifdef WRITE_DPS_SEQ_TAG_EN
                seq_n   = seq_q + SEQ_W'(1);
`endif
            end
            default: state_n = POLL_ADDR;
        endcase
        ready_n = (state_n == ACCEPT);
        busy_n  = !ready_n;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= POLL_ADDR;
            count_q        <= '0;
            sram_address   <= '0;
            sram_writedata <= '0;
            sram_write     <= 1'b0;
            in_ready       <= 1'b0;
            busy           <= 1'b1;
            drop_count     <= '0;
`ifdef WRITE_DPS_SEQ_TAG_EN
            seq_q          <= '0;
`endif
        end else begin
            state_q        <= state_n;
            count_q        <= count_n;
            sram_address   <= addr_n;
            sram_writedata <= wdata_n;
            sram_write     <= write_n;
            in_ready       <= ready_n;
            busy           <= busy_n;
            drop_count     <= drop_n;
`ifdef WRITE_DPS_SEQ_TAG_EN
            seq_q          <= seq_n;
`endif
        end
    end

endmodule

// File: tb/tb_write_dps_module.sv
// Directed self-checking bench for write_dps_module with a small mailbox model and write log.
module tb_write_dps_module;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] sram_readdata;
    logic [7:0]  sram_address;
    logic [31:0] sram_writedata;
    logic        sram_write;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_x;
    logic [9:0]  in_y;
    logic [7:0]  in_val;
    logic        flush;
    logic        busy;
    logic [15:0] drop_count;

    logic        hps_we;
    logic [31:0] hps_wdata;
    logic [31:0] flag_reg;

    logic [7:0]  la[$];
    logic [31:0] ld[$];
    int          lc[$];
    int          cyc = 0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    write_dps_module dut (
        .clock          (clock),
        .reset          (reset),
        .sram_readdata  (sram_readdata),
        .sram_address   (sram_address),
        .sram_writedata (sram_writedata),
        .sram_write     (sram_write),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_x           (in_x),
        .in_y           (in_y),
        .in_val         (in_val),
        .flush          (flush),
        .busy           (busy),
        .drop_count     (drop_count)
    );

    // Mailbox model: only address 0 is read back; HPS writes take priority.
    always @(posedge clock) begin
        if (hps_we)
            flag_reg <= hps_wdata;
        else if (sram_write && sram_address == 8'd0)
            flag_reg <= sram_writedata;
        sram_readdata <= (sram_address == 8'd0) ? flag_reg : 32'h0;
    end

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (sram_write === 1'b1) begin
            la.push_back(sram_address);
            ld.push_back(sram_writedata);
            lc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_write"},     32'(sram_write),     32'd0);
        check({p, "_address"},   32'(sram_address),   32'd0);
        check({p, "_writedata"}, sram_writedata,      32'd0);
        check({p, "_in_ready"},  32'(in_ready),       32'd0);
        check({p, "_busy"},      32'(busy),           32'd1);
        check({p, "_drop"},      32'(drop_count),     32'd0);
    endtask

    task automatic hps_write(input logic [31:0] v);
        hps_we    = 1'b1;
        hps_wdata = v;
        @(negedge clock);
        hps_we    = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        check(tag, 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [7:0] v);
        int t = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_val   = v;
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) check("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n, input string tag);
        int t = 0;
        while (la.size() < n && t < 1000) begin
            @(negedge clock);
            t++;
        end
        repeat (2) @(negedge clock);
        check(tag, 32'(la.size()), 32'(n));
    endtask

    task automatic check_wr(input int idx, input string tag, input logic [7:0] a, input logic [31:0] d);
        if (idx < la.size()) begin
            check({tag, "_addr"}, 32'(la[idx]), 32'(a));
            check({tag, "_data"}, ld[idx], d);
        end else begin
            check({tag, "_missing"}, 32'(la.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        int rdy_seen;
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
        in_x = '0; in_y = '0; in_val = '0;
        hps_we = 1'b0; hps_wdata = '0;

        // Reset values with the HPS still owning the mailbox.
        @(negedge clock);
        hps_write(32'd5);
        repeat (2) @(negedge clock);
        check_reset("reset");

        // HPS holds flag at 5: no writes, no ready.
        reset = 1'b1;
        rdy_seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (in_ready !== 1'b0) rdy_seen++;
        end
        check("hold_ready_seen", 32'(rdy_seen), 32'd0);
        check("hold_writes", 32'(la.size()), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);

        hps_write(32'd0);
        t = 1;
        while (in_ready !== 1'b1 && t < 10) begin
            @(negedge clock);
            t++;
        end
        check("clear_to_ready_window", 32'(t >= 3 && t <= 5), 32'd1);
        check("accept_busy", 32'(busy), 32'd0);

        // Three samples then flush.
        base = la.size();
        send(10'd10, 10'd20, 8'hFF);
        send(10'd639, 10'd479, 8'h7F);
        send(10'd0, 10'd0, 8'h00);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        wait_writes(base + 5, "b3_nwrites");
        check_wr(base + 0, "b3_w0", 8'd2, 32'h00A014FF);
        check_wr(base + 1, "b3_w1", 8'd3, 32'h27F1DF7F);
        check_wr(base + 2, "b3_w2", 8'd4, 32'h00000000);
        check_wr(base + 3, "b3_cnt", 8'd1, 32'd3);
        check_wr(base + 4, "b3_flag", 8'd0, 32'd1);
        check("b3_busy_after", 32'(busy), 32'd1);
        check("b3_ready_after", 32'(in_ready), 32'd0);

        // Full batch of 254 back-to-back samples, auto commit.
        hps_write(32'd0);
        wait_ready("full_ready");
        base = la.size();
        for (int i = 0; i < 254; i++)
            send(10'(i), 10'(i), 8'(i));
        check("full_ready_drop", 32'(in_ready), 32'd0);
        wait_writes(base + 256, "full_nwrites");
        for (int i = 0; i < 254; i++)
            check_wr(base + i, "full_data", 8'(i + 2), (32'(i) << 20) | (32'(i) << 8) | 32'(i));
        check_wr(base + 254, "full_cnt", 8'd1, 32'd254);
        check_wr(base + 255, "full_flag", 8'd0, 32'd1);
        check("full_consecutive", 32'(lc[base + 255] - lc[base]), 32'd255);

        // Idle flush ignored, then out-of-range drops.
        hps_write(32'd0);
        wait_ready("drop_ready");
        base = la.size();
        flush = 1'b1;
        repeat (3) @(negedge clock);
        flush = 1'b0;
        check("idle_flush_writes", 32'(la.size() - base), 32'd0);
        check("idle_flush_ready", 32'(in_ready), 32'd1);
        send(10'd640, 10'd0, 8'd1);
        send(10'd5, 10'd480, 8'd1);
        send(10'd5, 10'd5, 8'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        wait_writes(base + 3, "drop_nwrites");
        check_wr(base + 0, "drop_w0", 8'd2, 32'h00500501);
        check_wr(base + 1, "drop_cnt", 8'd1, 32'd1);
        check_wr(base + 2, "drop_flag", 8'd0, 32'd1);
        check("drop_count", 32'(drop_count), 32'd2);

        // Reset in the middle of a batch.
        hps_write(32'd0);
        wait_ready("mid_ready");
        base = la.size();
        send(10'd1, 10'd2, 8'd3);
        send(10'd4, 10'd5, 8'd6);
        reset = 1'b0;
        @(negedge clock);
        check_reset("mid_reset");
        repeat (2) @(negedge clock);
        check("mid_nwrites", 32'(la.size() - base), 32'd2);
        check_wr(base + 0, "mid_w0", 8'd2, 32'h00100203);
        check_wr(base + 1, "mid_w1", 8'd3, 32'h00400506);
        reset = 1'b1;
        wait_ready("restart_ready");
        base = la.size();
        flush = 1'b1;
        send(10'd7, 10'd8, 8'd9);
        flush = 1'b0;
        wait_writes(base + 3, "restart_nwrites");
        check_wr(base + 0, "restart_w0", 8'd2, 32'h00700809);
        check_wr(base + 1, "restart_cnt", 8'd1, 32'd1);
        check_wr(base + 2, "restart_flag", 8'd0, 32'd1);

`ifdef WRITE_DPS_SEQ_TAG_EN
        // Sequence tag advances per committed batch.
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        hps_write(32'd0);
        wait_ready("seq_ready_a");
        base = la.size();
        flush = 1'b1;
        send(10'd1, 10'd1, 8'd1);
        flush = 1'b0;
        wait_writes(base + 3, "seq_a_nwrites");
        check_wr(base + 0, "seq_a_data", 8'd2, 32'h00100101);
        check_wr(base + 2, "seq_a_flag", 8'd0, 32'h00000001);
        hps_write(32'd0);
        wait_ready("seq_ready_b");
        base = la.size();
        flush = 1'b1;
        send(10'd2, 10'd2, 8'd2);
        flush = 1'b0;
        wait_writes(base + 3, "seq_b_nwrites");
        check_wr(base + 0, "seq_b_data", 8'd2, 32'h40200202);
        check_wr(base + 2, "seq_b_flag", 8'd0, 32'h40000001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
